// File: rtl/serial_rx_fifo.sv
// Receive character FIFO between the serial UART and the PIO read side.
// Optional SERIAL_RX_FIFO_RTS_EN adds a registered active-low request-to-send output.
module serial_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       charReceived,
   input  logic [WIDTH-1:0]           rxData,
   input  logic                       rdReq,
   input  logic                       clrOverflow,
   output logic [WIDTH-1:0]           rdData,
   output logic                       dataReady,
   output logic [$clog2(DEPTH+1)-1:0] count,
`ifdef SERIAL_RX_FIFO_RTS_EN
   output logic                       rtsN,
`endif
   output logic                       overflow
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             prev_rcvd_q, prev_rd_q;
   logic             push, pop, full, wr_en;

   always_comb begin
      push       = charReceived & ~prev_rcvd_q;
      pop        = rdReq & ~prev_rd_q & (count_q != '0);
      full       = (count_q == FULL_CNT);
      // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
      wr_en      = push & (~full | pop);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !pop)      count_d = count_q + 1'b1;
      else if (!wr_en && pop) count_d = count_q - 1'b1;
      if (clrOverflow)                 overflow_d = 1'b0;
      else if (push && full && !pop)   overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         // Held-high strobes must not count as edges when reset releases.
         prev_rcvd_q <= 1'b1;
         prev_rd_q   <= 1'b1;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         prev_rcvd_q <= charReceived;
         prev_rd_q   <= rdReq;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_en) mem_q[wr_ptr_q] <= rxData;
   end

`ifdef SERIAL_RX_FIFO_RTS_EN
   localparam logic [CW-1:0] RTS_CNT = CW'(DEPTH-2);
   logic rts_n_q, rts_n_d;

   always_comb rts_n_d = (count_d >= RTS_CNT);

   always_ff @(posedge clk) begin
      if (reset) rts_n_q <= 1'b0;
      else       rts_n_q <= rts_n_d;
   end

   assign rtsN = rts_n_q;
`endif

   assign rdData    = mem_q[rd_ptr_q];
   assign dataReady = (count_q != '0);
   assign count     = count_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Scoreboard bench for serial_rx_fifo: queue model of pushed bytes, checked on every pop.
module tb_serial_rx_fifo;
   localparam int DEPTH = 16;
   localparam int WIDTH = 8;
   localparam int CW    = $clog2(DEPTH+1);

   logic             clk = 0, reset = 1, charReceived = 0, rdReq = 0, clrOverflow = 0;
   logic [WIDTH-1:0] rxData = '0;
   logic [WIDTH-1:0] rdData;
   logic             dataReady, overflow;
   logic [CW-1:0]    count;
`ifdef SERIAL_RX_FIFO_RTS_EN
   logic             rtsN;
`endif

   serial_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .charReceived(charReceived), .rxData(rxData),
      .rdReq(rdReq), .clrOverflow(clrOverflow), .rdData(rdData),
      .dataReady(dataReady), .count(count),
`ifdef SERIAL_RX_FIFO_RTS_EN
      .rtsN(rtsN),
`endif
      .overflow(overflow));

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   logic [WIDTH-1:0] sb_q[$];
   logic             m_ovf = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1; tick(); reset = 0;
      sb_q.delete(); m_ovf = 0;
      tick();
   endtask

   task automatic do_push(input logic [WIDTH-1:0] b);
      rxData = b; charReceived = 1; tick();
      if (sb_q.size() < DEPTH) sb_q.push_back(b); else m_ovf = 1;
      chk("push_ready", dataReady, 1);
      charReceived = 0; tick();
      chk("push_cnt", count, sb_q.size());
      chk("push_ovf", overflow, m_ovf);
   endtask

   task automatic do_pop();
      if (sb_q.size() > 0) chk("rd_data", rdData, sb_q[0]);
      rdReq = 1; tick();
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      rdReq = 0; tick();
      chk("pop_cnt", count, sb_q.size());
      chk("pop_ready", dataReady, sb_q.size() != 0);
   endtask

   task automatic do_both(input logic [WIDTH-1:0] b);
      if (sb_q.size() > 0) chk("both_head", rdData, sb_q[0]);
      rxData = b; charReceived = 1; rdReq = 1; tick();
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      sb_q.push_back(b);
      charReceived = 0; rdReq = 0; tick();
      chk("both_cnt", count, sb_q.size());
      chk("both_ovf", overflow, m_ovf);
   endtask

   task automatic drain();
      while (sb_q.size() > 0) do_pop();
   endtask

   initial begin
      tick(); do_reset();
      chk("rst_cnt", count, 0);
      chk("rst_ready", dataReady, 0);
      chk("rst_ovf", overflow, 0);

      // basic ordering
      do_push(8'h41); do_push(8'h42); do_push(8'h43);
      chk("t1_head", rdData, 8'h41);
      drain();
      chk("t1_empty", dataReady, 0);

      // wrap-around
      for (int i = 0; i < 16; i++) do_push(8'(i));
      chk("full_cnt", count, DEPTH);
      drain();
      for (int i = 16; i < 20; i++) do_push(8'(i));
      drain();

      // overflow: the dropped 0xAA must never appear
      for (int i = 0; i < 16; i++) do_push(8'(8'h60 + i));
      do_push(8'hAA);
      chk("ovf_set", overflow, 1);
      drain();
      chk("ovf_sticky", overflow, 1);
      clrOverflow = 1; tick(); clrOverflow = 0; m_ovf = 0; tick();
      chk("ovf_clr", overflow, 0);

      // simultaneous push/pop when full and when empty
      for (int i = 0; i < 16; i++) do_push(8'(8'h80 + i));
      do_both(8'h55);
      chk("both_full_cnt", count, DEPTH);
      drain();
      do_both(8'h66);
      chk("both_empty_cnt", count, 1);
      drain();

      // strobes held high across reset, then reset discards buffered bytes
      do_push(8'h11); do_push(8'h22);
      charReceived = 1; rdReq = 1;
      reset = 1; tick(); reset = 0; sb_q.delete(); m_ovf = 0;
      tick(); tick();
      chk("hold_cnt", count, 0);
      chk("hold_ready", dataReady, 0);
      charReceived = 0; rdReq = 0; tick();
      do_push(8'h77);
      chk("post_rst_head", rdData, 8'h77);
      do_pop();
      chk("post_rst_cnt", count, 0);

`ifdef SERIAL_RX_FIFO_RTS_EN
      do_reset();
      chk("rts_rst", rtsN, 0);
      for (int i = 0; i < 13; i++) do_push(8'(i));
      chk("rts_13", rtsN, 0);
      do_push(8'd13);
      chk("rts_14", rtsN, 1);
      do_pop();
      chk("rts_pop", rtsN, 0);
      drain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/serial_rx_fifo.md
# serial_rx_fifo

Receive-side character buffer between the `serial` UART block and the Nios II receive PIOs. It captures each byte that `serial` presents on `parDataIn`/`charReceived` into a DEPTH-entry FIFO, so bursts sent by the opposing Battleship board are not lost while software is busy. Software drains the FIFO one byte per edge of a PIO read strobe. Overflow is reported through a sticky flag.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `WIDTH`, 8: character width in bits.
- `clk`  in  1  system clock (CLK at top level).
- `reset`  in  1  synchronous, active-high reset.
- `charReceived`  in  1  level from `serial`. A rising edge means `rxData` holds a new character.
- `rxData`  in  WIDTH  received character from `serial` (`parDataIn`).
- `rdReq`  in  1  PIO read strobe. Each rising edge pops one entry.
- `clrOverflow`  in  1  level; while high, clears `overflow`.
- `rdData`  out  WIDTH  head entry, first-word-fall-through.
- `dataReady`  out  1  FIFO not empty.
- `count`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set when a character was dropped.
- `rtsN`  out  1  active-low request-to-send. Present only with SERIAL_RX_FIFO_RTS_EN.

## Operation
- Edge detectors:
  - `prevRcvd` and `prevRd` register `charReceived` and `rdReq` every cycle.
  - `push = charReceived & ~prevRcvd`.
  - `pop = rdReq & ~prevRd & (count != 0)`.
- Storage:
  - WIDTH×DEPTH register array.
  - `wrPtr` and `rdPtr` are log2(DEPTH) bits and wrap modulo DEPTH with no special case.
  - `count` is a separate register.
- `push` with `count < DEPTH`: write `rxData` to `mem[wrPtr]`, advance `wrPtr`, increment `count`.
- `push` with `count == DEPTH` and no `pop`: drop the byte, leave pointers and `count` unchanged, set `overflow`.
- `push` with `pop` in the same cycle:
  - Both happen; `count` is unchanged.
  - When full, the pop frees the slot, the write succeeds, and `overflow` is not set.
  - When empty, `pop` is already suppressed, so only the push happens.
- `pop` while empty: ignored. No underflow flag; pointers are unchanged.
- `rdData = mem[rdPtr]` (combinational from the array). Its value is undefined when `dataReady == 0`; benches do not check it then.
- `overflow` priority: `clrOverflow` has priority over a set in the same cycle.
- Reset (synchronous, on any edge with `reset == 1`):
  - Pointers, `count` and `overflow` go to 0, so `dataReady` is 0.
  - `prevRcvd` and `prevRd` are forced to 1, so a strobe held high through reset does not push or pop on release.
  - Array contents are not cleared.
- Reset during a burst: all buffered bytes are discarded. The first push after reset needs a fresh low→high on `charReceived`.

## Timing
- Push latency: `charReceived` sampled high at edge N (low at N−1) → write commits at N → `dataReady` = 1 and `count` updated after edge N.
- Pop latency: `rdReq` rising sampled at edge N → `rdPtr` and `count` update at N → next head visible on `rdData` after N.
- Throughput: one push and one pop per clock maximum. Each strobe must be low for at least one clock between events.
- All outputs are registered or derived from registers with no input-to-output combinational path, except `rdData`, which is a mux from registers.

## Configuration
- `SERIAL_RX_FIFO_RTS_EN` defined:
  - Adds registered output `rtsN`.
  - `rtsN` = 1 (stop sender) when `count ≥ DEPTH−2` after the current update; `rtsN` = 0 otherwise.
  - Reset value is 0.
- `SERIAL_RX_FIFO_RTS_EN` undefined: the `rtsN` port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset then three pushes of 0x41, 0x42, 0x43 → `count` = 3, `dataReady` = 1, `rdData` = 0x41. Three `rdReq` edges → `rdData` shows 0x42, then 0x43, then `count` = 0 and `dataReady` = 0.
- Wrap-around (DEPTH = 16): push 0x00..0x0F, pop all 16, push 0x10..0x13 → pops return 0x10..0x13 in order and `count` ends at 0.
- Overflow: fill to 16, push 0xAA → `count` stays 16, `overflow` = 1, and the 16th pop returns the 16th pushed byte, not 0xAA. Then `clrOverflow` = 1 for one cycle → `overflow` = 0.
- Simultaneous events:
  - When full, push 0x55 and pop on the same edge → `count` = 16, `overflow` = 0, and 0x55 is the last byte out.
  - When empty, push and pop on the same edge → `count` = 1.
- `charReceived` and `rdReq` held high across reset, released low, then one clean edge each → exactly one push and one pop occur; `count` = 0.
- With `SERIAL_RX_FIFO_RTS_EN`: push 13 → `rtsN` = 0; 14th push → `rtsN` = 1 after that edge; one pop → `rtsN` = 0.
